// File: rtl/fault_sim_pkg.sv
// Shared types and helpers for the stuck-at fault sweep sequencer.
// Holds the sweep state enum, default sizes and a response slicer.
package fault_sim_pkg;

    localparam int DEF_NUM_FAULTS = 6;
    localparam int DEF_PAT_W      = 4;
    localparam int DEF_OUT_W      = 2;

    // Upper bounds for the generic slicer below.
    localparam int RESP_MAX_W  = 256;
    localparam int SLICE_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    // Returns fault idx's w-bit response, zero-extended to SLICE_MAX_W.
    // Callers zero-extend the packed vector to RESP_MAX_W first.
    function automatic logic [SLICE_MAX_W-1:0] resp_slice(
        input logic [RESP_MAX_W-1:0] vec,
        input int                    idx,
        input int                    w
    );
        logic [RESP_MAX_W-1:0]  sh;
        logic [SLICE_MAX_W-1:0] mask;
        sh   = vec >> (idx * w);
        mask = (SLICE_MAX_W'(1) << w) - SLICE_MAX_W'(1);
        return sh[SLICE_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/fault_resp_cmp.sv
// Combinational compare of every faulty response against the golden one.
// Ports: good_resp (OUT_W), fault_resp (NUM_FAULTS*OUT_W) -> mismatch (NUM_FAULTS).
module fault_resp_cmp
    import fault_sim_pkg::*;
#(
    parameter int NUM_FAULTS = DEF_NUM_FAULTS,
    parameter int OUT_W      = DEF_OUT_W
) (
    input  logic [OUT_W-1:0]            good_resp,
    input  logic [NUM_FAULTS*OUT_W-1:0] fault_resp,
    output logic [NUM_FAULTS-1:0]       mismatch
);

    logic [RESP_MAX_W-1:0]  resp_ext;
    logic [SLICE_MAX_W-1:0] good_ext;

    assign resp_ext = RESP_MAX_W'(fault_resp);
    assign good_ext = SLICE_MAX_W'(good_resp);

    always_comb begin
        mismatch = '0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            mismatch[i] = resp_slice(resp_ext, i, OUT_W) != good_ext;
        end
    end

endmodule

// File: rtl/fault_sweep_ctrl.sv
// Stuck-at fault sweep sequencer: walks all patterns, settles, compares,
// and records per-fault detection and first detecting pattern.
// Ports: clk, rst (sync, active-high), start, early_stop, pat,
// good_resp, fault_resp, busy, done, detected, first_pat, det_count.
module fault_sweep_ctrl
    import fault_sim_pkg::*;
#(
    parameter int NUM_FAULTS = DEF_NUM_FAULTS,
    parameter int PAT_W      = DEF_PAT_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int SETTLE     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  early_stop,
    output logic [PAT_W-1:0]                      pat,
    input  logic [OUT_W-1:0]                      good_resp,
    input  logic [NUM_FAULTS*OUT_W-1:0]           fault_resp,
    output logic                                  busy,
    output logic                                  done,
    output logic [NUM_FAULTS-1:0]                 detected,
    output logic [NUM_FAULTS*PAT_W-1:0]           first_pat,
    output logic [$clog2(NUM_FAULTS+1)-1:0]       det_count
);

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam int DC_W  = $clog2(NUM_FAULTS + 1);

    localparam logic [PAT_W-1:0] PAT_MAX  = {PAT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                 state;
    state_t                 state_nx;
    logic [CNT_W-1:0]       cnt;
    logic                   es_q;
    logic [NUM_FAULTS-1:0]  mismatch;
    logic [NUM_FAULTS-1:0]  new_det;
    logic [NUM_FAULTS-1:0]  det_nx;
    logic [DC_W-1:0]        det_pop;
    logic                   last;

    fault_resp_cmp #(
        .NUM_FAULTS (NUM_FAULTS),
        .OUT_W      (OUT_W)
    ) u_cmp (
        .good_resp  (good_resp),
        .fault_resp (fault_resp),
        .mismatch   (mismatch)
    );

    // Only first detections count; an already set bit is never rewritten.
    assign new_det = mismatch & ~detected;
    assign det_nx  = detected | new_det;

    always_comb begin
        det_pop = '0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            det_pop = det_pop + DC_W'(det_nx[i]);
        end
    end

    // Sweep ends at the top pattern or, with early stop, on full coverage.
    assign last = (pat == PAT_MAX) || (es_q && (&det_nx));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt <= CNT_ONE) begin
                    state_nx = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                state_nx = last ? ST_DONE : ST_SETTLE;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == ST_SETTLE) || (state == ST_COMPARE);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat       <= '0;
            cnt       <= '0;
            es_q      <= 1'b0;
            detected  <= '0;
            first_pat <= '0;
            det_count <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        pat       <= '0;
                        cnt       <= CNT_LOAD;
                        es_q      <= early_stop;
                        detected  <= '0;
                        first_pat <= '0;
                        det_count <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt > CNT_ONE) begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_COMPARE: begin
                    detected  <= det_nx;
                    det_count <= det_pop;
                    for (int i = 0; i < NUM_FAULTS; i++) begin
                        if (new_det[i]) begin
                            first_pat[i*PAT_W +: PAT_W] <= pat;
                        end
                    end
                    if (!last) begin
                        pat <= pat + PAT_W'(1);
                        cnt <= CNT_LOAD;
                    end
                end
                ST_DONE: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fault_sweep_ctrl.sv
// Self-checking bench for fault_sweep_ctrl: directed and random sweeps
// checked cycle by cycle against a pattern-level reference model.
module tb_fault_sweep_ctrl;

    localparam int NF = 6;
    localparam int PW = 4;
    localparam int OW = 2;
    localparam int ST = 1;
    localparam int NPAT = 1 << PW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              early_stop = 1'b0;
    logic [PW-1:0]     pat;
    logic [OW-1:0]     good_resp;
    logic [NF*OW-1:0]  fault_resp;
    logic              busy;
    logic              done;
    logic [NF-1:0]     detected;
    logic [NF*PW-1:0]  first_pat;
    logic [2:0]        det_count;

    int checks = 0;
    int errors = 0;

    // Which patterns make each faulty instance differ, and how.
    logic [NPAT-1:0] mask [NF];
    logic [OW-1:0]   flip [NF];

    fault_sweep_ctrl #(
        .NUM_FAULTS (NF),
        .PAT_W      (PW),
        .OUT_W      (OW),
        .SETTLE     (ST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .early_stop (early_stop),
        .pat        (pat),
        .good_resp  (good_resp),
        .fault_resp (fault_resp),
        .busy       (busy),
        .done       (done),
        .detected   (detected),
        .first_pat  (first_pat),
        .det_count  (det_count)
    );

    always #5 clk = ~clk;

    // Circuit instances under test: golden function plus fault flips.
    always_comb begin
        good_resp  = pat[1:0] ^ pat[3:2];
        fault_resp = '0;
        for (int i = 0; i < NF; i++) begin
            fault_resp[i*OW +: OW] = good_resp ^ (mask[i][pat] ? flip[i] : 2'b00);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_masks(input logic [NPAT-1:0] m0, input logic [NPAT-1:0] m1,
                             input logic [NPAT-1:0] m2, input logic [NPAT-1:0] m3,
                             input logic [NPAT-1:0] m4, input logic [NPAT-1:0] m5);
        mask[0] = m0; mask[1] = m1; mask[2] = m2;
        mask[3] = m3; mask[4] = m4; mask[5] = m5;
        for (int i = 0; i < NF; i++) flip[i] = OW'($urandom_range(1, 3));
    endtask

    task automatic rand_masks();
        for (int i = 0; i < NF; i++) begin
            // Sparse masks so that first-detection order varies.
            mask[i] = NPAT'($urandom) & NPAT'($urandom) & NPAT'($urandom);
            flip[i] = OW'($urandom_range(1, 3));
        end
    endtask

    // One sweep. repulse/rst_cyc: cycle to pulse start/rst, 0 for none.
    task automatic sweep(input bit es, input int repulse, input int rst_cyc);
        logic [NF-1:0]    e_det;
        logic [NF*PW-1:0] e_first;
        int               e_cnt;
        int               kend;
        int               last_cmp;
        int               done_cyc;
        int               k;
        logic [PW-1:0]    e_pat;

        // Reference: walk patterns in order, first hit wins.
        e_det   = '0;
        e_first = '0;
        kend    = NPAT - 1;
        for (int p = 0; p < NPAT; p++) begin
            for (int i = 0; i < NF; i++) begin
                if (mask[i][p] && !e_det[i]) begin
                    e_det[i] = 1'b1;
                    e_first[i*PW +: PW] = PW'(p);
                end
            end
            if (es && e_det == {NF{1'b1}}) begin
                kend = p;
                break;
            end
        end
        e_cnt = $countones(e_det);
        last_cmp = (kend + 1) * (ST + 1);
        done_cyc = last_cmp + 1;

        @(negedge clk);
        start = 1'b1;
        early_stop = es;
        for (int cyc = 1; cyc <= done_cyc + 2; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            early_stop = $urandom_range(0, 1);
            if (rst_cyc != 0 && cyc == rst_cyc + 1) begin
                rst = 1'b0;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_pat", pat, 0);
                chk("rst_det", detected, 0);
                chk("rst_first", first_pat, 0);
                chk("rst_cnt", det_count, 0);
                return;
            end
            k = (cyc <= last_cmp) ? (cyc - 1) / (ST + 1) : kend;
            e_pat = PW'(k);
            chk($sformatf("busy_c%0d", cyc), busy, cyc <= last_cmp);
            chk($sformatf("done_c%0d", cyc), done, cyc == done_cyc);
            chk($sformatf("pat_c%0d", cyc), pat, e_pat);
            if (cyc == done_cyc) begin
                chk("detected", detected, e_det);
                chk("first_pat", first_pat, e_first);
                chk("det_count", det_count, e_cnt);
            end
            if (cyc == repulse) start = 1'b1;
            if (cyc == rst_cyc) rst = 1'b1;
        end
    endtask

    initial begin
        set_masks('0, '0, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
        chk("reset_pat", pat, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_det", detected, 0);
        chk("reset_first", first_pat, 0);
        chk("reset_cnt", det_count, 0);
        rst = 1'b0;

        sweep(1'b0, 0, 0);
        set_masks(16'h0400, '0, '0, '0, '0, '0);
        sweep(1'b0, 0, 0);
        set_masks('0, '0, 16'h0208, '0, '0, '0);
        sweep(1'b0, 0, 0);
        set_masks(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
        sweep(1'b1, 0, 0);
        rand_masks();
        sweep(1'b0, 10, 0);
        rand_masks();
        sweep(1'b0, 0, 15);
        sweep(1'b0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            rand_masks();
            if (r[0]) begin
                for (int i = 0; i < NF; i++) mask[i] = mask[i] | NPAT'(1 << $urandom_range(0, NPAT-1));
            end
            sweep(1'($urandom_range(0, 1)), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
